// File: rtl/mode_select_ctrl_if.sv
// Button inputs and mode outputs between the board front end and the counter block.
// The master side drives the raw buttons; the slave (mode_select_ctrl) returns mode and tick.
interface mode_select_ctrl_if;
    logic       btn_next;
    logic       btn_clr;
    logic [1:0] sel;
    logic       sel_changed;
    logic       tick;

    modport master (
        output btn_next,
        output btn_clr,
        input  sel,
        input  sel_changed,
        input  tick
    );

    modport slave (
        input  btn_next,
        input  btn_clr,
        output sel,
        output sel_changed,
        output tick
    );
endinterface

// File: rtl/mode_select_ctrl.sv
// Synchronises and debounces the next/clr buttons and keeps the 2-bit counter mode.
// Define MODE_TICK_GEN_EN to build the count-enable tick generator; otherwise tick is 0.
module mode_select_ctrl #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    mode_select_ctrl_if.slave bus
);

    localparam int unsigned     DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    // Bit 0 is btn_next, bit 1 is btn_clr throughout.
    logic [1:0]             w_raw;
    logic [1:0]             w_sync;
    logic [SYNC_STAGES-1:0] r_sync [2];

    logic [DebW-1:0]        r_deb_cnt [2];
    logic [DebW-1:0]        w_deb_cnt_nxt [2];
    logic [1:0]             r_deb;
    logic [1:0]             w_deb_nxt;
    logic [1:0]             r_deb_prev;
    logic [1:0]             w_press;

    logic [1:0]             r_sel;
    logic [1:0]             w_sel_nxt;
    logic [1:0]             r_sel_prev;
    logic                   r_sel_changed;

    assign w_raw = {bus.btn_clr, bus.btn_next};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_sync[b] = r_sync[b][SYNC_STAGES-1];
        end
    end

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_deb_nxt[b]     = r_deb[b];
            w_deb_cnt_nxt[b] = '0;
            if (w_sync[b] != r_deb[b]) begin
                if (r_deb_cnt[b] == DebMax) begin
                    w_deb_nxt[b] = w_sync[b];
                end else begin
                    w_deb_cnt_nxt[b] = r_deb_cnt[b] + DebW'(1);
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_prev;

    always_comb begin
        w_sel_nxt = r_sel;
        if (w_press[1]) begin
            w_sel_nxt = 2'd0;
        end else if (w_press[0]) begin
            w_sel_nxt = r_sel + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                r_sync[b]    <= '0;
                r_deb_cnt[b] <= '0;
            end
            r_deb         <= '0;
            r_deb_prev    <= '0;
            r_sel         <= '0;
            r_sel_prev    <= '0;
            r_sel_changed <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_sync[b]    <= {r_sync[b][SYNC_STAGES-2:0], w_raw[b]};
                r_deb_cnt[b] <= w_deb_cnt_nxt[b];
            end
            r_deb         <= w_deb_nxt;
            r_deb_prev    <= r_deb;
            r_sel         <= w_sel_nxt;
            r_sel_prev    <= r_sel;
            r_sel_changed <= (r_sel != r_sel_prev);
        end
    end

    assign bus.sel         = r_sel;
    assign bus.sel_changed = r_sel_changed;

`ifdef MODE_TICK_GEN_EN
    localparam int unsigned      TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

    logic [TickW-1:0] r_tick_cnt;
    logic [TickW-1:0] w_tick_cnt_nxt;

    // A mode change restarts the period so the first tick is a full TICK_DIV away.
    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt + TickW'(1);
        if (r_sel_changed || (r_tick_cnt == TickMax)) begin
            w_tick_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
        end
    end

    assign bus.tick = (r_tick_cnt == TickMax) && !r_sel_changed;
`else
    logic w_unused_tick_div;
    assign w_unused_tick_div = ^TICK_DIV;
    assign bus.tick          = 1'b0;
`endif

endmodule

// File: doc/mode_select_ctrl.md
Name: mode_select_ctrl

Overview:
- Front-end control stage that feeds the up/down counter block.
- Synchronises and debounces two board push-buttons and maintains the 2-bit counter mode `sel` (0 zero, 1 up, 2 down, 3 up/down).
- Optionally generates a single-cycle count-enable tick, so the counter runs on `clk` with an enable instead of a derived clock.

Parameters:
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 2.
- TICK_DIV, 100000000, `clk` cycles per tick period; minimum 2.
- SYNC_STAGES, 2, synchroniser flop depth per button; minimum 2.

Ports:
- clk  in  1  system clock; all flops are on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw asynchronous button; each press advances the mode.
- btn_clr  in  1  raw asynchronous button; a press forces mode 0.
- sel  out  2  current counter mode, driven by a register.
- sel_changed  out  1  one-cycle pulse, asserted in the cycle after `sel` takes a new value.
- tick  out  1  one-cycle count-enable pulse.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- Reset values: synchroniser flops 0, debounce counters 0, debounced levels 0, sel=0, sel_changed=0, tick=0, tick counter 0. Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Synchroniser: each button passes through a chain of SYNC_STAGES flops. Only the last stage is used downstream.
- Debounce (independent per button):
  - The counter clears whenever the synchronised level equals the debounced level.
  - While the two differ, the counter increments by 1 each cycle.
  - In the cycle the counter equals DEB_CYCLES-1 and the levels still differ, the debounced level updates and the counter clears.
  - Result: a level change is accepted exactly DEB_CYCLES cycles after the synchronised input changes. Glitches shorter than DEB_CYCLES restart the count and produce no change.
  - Counter width is clog2(DEB_CYCLES). It must never wrap.
- Edge detect: a press is a 0->1 transition of the debounced level. The release edge is ignored.
- Mode register, priority highest first:
  1. clr press: sel <= 0.
  2. next press: sel <= sel+1 modulo 4, so 3 wraps to 0.
  3. Otherwise sel holds.
  - A clr press and a next press in the same cycle give sel=0; clr wins.
- sel_changed: registered flag (new sel != old sel). A clr press while sel is already 0 produces no pulse.
- Button held through reset: the debounced level restarts at 0, so the held level is accepted as a press DEB_CYCLES (+sync latency) after reset release. This is the required behaviour.
- Latency: from a raw edge to the sel update is SYNC_STAGES + DEB_CYCLES + 1 cycles. sel_changed follows one cycle after that.

Optional Feature:
- Macro: MODE_TICK_GEN_EN.
- Defined:
  - A tick counter counts 0..TICK_DIV-1 and wraps. tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1.
  - In the cycle sel_changed is 1, the counter is forced to 0 and tick is 0. The first tick after a mode change therefore arrives a full TICK_DIV cycles later.
  - Counter width is clog2(TICK_DIV).
- Not defined: no tick counter is built and tick is tied to 0.

Test Plan (DEB_CYCLES=4, TICK_DIV=8, SYNC_STAGES=2, MODE_TICK_GEN_EN defined):
- Assert rst asynchronously mid-clock while sel=2 and the tick counter is at 5 -> sel=0, tick=0 and sel_changed=0 immediately. The first tick comes 8 cycles after reset release.
- btn_next held high for 20 cycles -> sel goes 0->1 exactly 7 cycles after the raw rise. sel_changed pulses once. There is no second increment while the button is held.
- btn_next shows 3-cycle high glitches separated by 1-cycle lows -> sel stays 0 and sel_changed stays 0.
- Four clean btn_next presses -> sel steps 1,2,3,0. sel_changed pulses 4 times.
- With sel=3, btn_next and btn_clr rise in the same cycle -> sel=0 and sel_changed pulses once. Then a btn_clr press at sel=0 -> no sel_changed pulse.
- Free-running with sel=1 -> tick every 8 cycles. A btn_next press restarts the period: tick is 0 in the sel_changed cycle, and the next tick comes 8 cycles later.
